counter_driver: RTL and testbench
=================================

// Module: counter_driver
// PURPOSE
//  Command-side master for the loadable up/down counter register (inc/dec/ld/in/out).
//  Accepts one request at a time: a target value plus a mode. It then drives the
//  counter's inc/dec/ld strobes to walk it to the target, or loads the target directly.
//  It verifies the result against the counter's output and signals done/err.
// PARAMETERS
//  W  6  counter width in bits; matches the counter register.
// PORTS
//  clk          in   1  clock, rising edge
//  rst          in   1  reset, asynchronous, active-low
//  req_valid    in   1  request present
//  req_ready    out  1  driver idle, request accepted when valid&&ready
//  req_mode     in   1  0 = WALK (inc/dec steps), 1 = LOAD (single ld)
//  req_target   in   W  target counter value
//  cnt_val      in   W  counter out, fed back
//  cnt_inc      out  1  counter increment strobe
//  cnt_dec      out  1  counter decrement strobe
//  cnt_ld       out  1  counter load strobe
//  cnt_in       out  W  counter load data
//  busy         out  1  request in progress (state != IDLE)
//  done         out  1  one-cycle pulse, request complete
//  err          out  1  sticky: counter != target at completion; cleared on next accept
//  step_count   out  W  number of inc/dec strobes issued for the last/current request
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; cnt_inc/dec/ld=0; cnt_in=0; done=0; err=0; step_count=0.
//   req_ready is 1 once rst=1. Reset mid-operation drops all strobes immediately.
//  States: IDLE, STEP, LOAD, DONE. All outputs are decoded from registers only;
//   there is no combinational path from inputs to outputs.
//  Accept (IDLE, req_valid=1):
//   - target_q <= req_target; shadow <= cnt_val; step_count <= 0; err <= 0.
//   - Direction dir_up is computed from (cnt_val, req_target).
//   - Next state is LOAD if req_mode=1, else STEP.
//  STEP:
//   - If shadow != target_q: drive cnt_inc=dir_up or cnt_dec=!dir_up for this cycle;
//     shadow +/-= 1 (mod 2^W); step_count += 1.
//   - If shadow == target_q: no strobe; go to DONE.
//   - cnt_inc and cnt_dec are never high together. cnt_ld is never high in STEP.
//  LOAD: drive cnt_ld=1 and cnt_in=target_q for exactly one cycle; go to DONE.
//  DONE: done=1 for one cycle. err <= (cnt_val != target_q). Go to IDLE.
//  Latency: WALK of N steps gives N strobe cycles, then 1 compare cycle, then the done
//   cycle. Done appears N+2 cycles after accept. LOAD gives done 2 cycles after accept.
//  Boundaries:
//   - target == current: zero strobes, step_count=0, done 2 cycles after accept.
//   - Wrap-around: shadow arithmetic is mod 2^W, identical to the counter.
//   - req_valid while busy: ignored; req_ready=0, the request is held by the sender.
//   - cnt_in holds target_q outside LOAD (don't-care to the counter, but stable).
// CONFIGURATION
//  CNT_DRV_SHORTEST_EN undefined: direct direction. dir_up = (target > current),
//   unsigned. Worst case is 2^W-1 steps.
//  CNT_DRV_SHORTEST_EN defined: shortest path mod 2^W.
//   - d = (target - current) mod 2^W; dir_up = (d <= 2^(W-1)).
//   - Ties go up. Walks may cross 0/2^W-1. Worst case is 2^(W-1) steps.
// STRUCTURE
//  Package cnt_drv_pkg: state encoding (IDLE/STEP/LOAD/DONE), MODE_WALK=1'b0, MODE_LOAD=1'b1.
//  Sub-module cnt_drv_dir: combinational (current, target) -> dir_up. It contains the
//   only CNT_DRV_SHORTEST_EN code.
//  Top: FSM, shadow/target/step registers, strobe decode.
// TESTING  (W=6, bench instantiates the real counter register as the load)
//  1. Hold rst=0 -> all strobes, done, err, step_count = 0. Release -> req_ready=1, busy=0.
//  2. Counter=5, WALK target=9 -> cnt_inc high 4 consecutive cycles; counter=9;
//     done at accept+6; step_count=4; err=0.
//  3. Counter=9, WALK target=9 -> no strobes; done at accept+2; step_count=0.
//  4. LOAD target=37 -> cnt_ld=1 with cnt_in=37 for one cycle; counter=37; done at accept+2.
//  5. Counter=2, WALK target=62:
//     - Without macro: 60 cnt_inc cycles.
//     - With macro: 4 cnt_dec cycles (2,1,0,63,62).
//     - Both: step_count matches the strobe count; err=0.
//  6. Reset pulse in the middle of test 2, then a counter stuck at its value during a WALK:
//     - Reset: strobes drop asynchronously, IDLE after release.
//     - Stuck counter: err=1 at done, cleared by the next accept.

Source files
------------

// File: rtl/cnt_drv_pkg.sv
// Shared types for the counter driver: FSM state encoding and request modes.
// Optional build macro CNT_DRV_SHORTEST_EN is consumed only by cnt_drv_dir.
package cnt_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic MODE_WALK = 1'b0;
    localparam logic MODE_LOAD = 1'b1;

endpackage

// File: rtl/cnt_drv_dir.sv
// Walk direction selector: decides whether to count up or down from current to target.
// Default is a direct unsigned compare; CNT_DRV_SHORTEST_EN picks the shortest path mod 2^W.
module cnt_drv_dir #(
    parameter int W = 6
) (
    input  logic [W-1:0] current,
    input  logic [W-1:0] target,
    output logic         dir_up
);

`ifdef CNT_DRV_SHORTEST_EN
    localparam logic [W:0] HALF = {{W{1'b0}}, 1'b1} << (W - 1);

    logic [W-1:0] dist;

    // Forward distance wraps naturally in W bits; a tie at exactly half goes up.
    assign dist   = target - current;
    assign dir_up = {1'b0, dist} <= HALF;
`else
    assign dir_up = target > current;
`endif

endmodule

// File: rtl/counter_driver.sv
// Command-side master for the loadable up/down counter: walks or loads it to a target
// and checks the result. Build macro CNT_DRV_SHORTEST_EN selects shortest-path walking.
module counter_driver
    import cnt_drv_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_mode,
    input  logic [W-1:0] req_target,
    input  logic [W-1:0] cnt_val,
    output logic         cnt_inc,
    output logic         cnt_dec,
    output logic         cnt_ld,
    output logic [W-1:0] cnt_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] step_count
);

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] target_q;
    logic [W-1:0] shadow_q;
    logic [W-1:0] step_q;
    logic         dir_q;
    logic         err_q;
    logic         dir_up;
    logic         accept;
    logic         at_target;
    logic         stepping;

    cnt_drv_dir #(.W(W)) u_dir (
        .current (cnt_val),
        .target  (req_target),
        .dir_up  (dir_up)
    );

    assign accept    = (state == ST_IDLE) && req_valid;
    assign at_target = (shadow_q == target_q);
    assign stepping  = (state == ST_STEP) && !at_target;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid) state_nxt = (req_mode == MODE_LOAD) ? ST_LOAD : ST_STEP;
            ST_STEP: if (at_target) state_nxt = ST_DONE;
            ST_LOAD: state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The shadow tracks what the counter should hold, so strobes never depend on cnt_val.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target_q <= '0;
            shadow_q <= '0;
            step_q   <= '0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                target_q <= req_target;
                shadow_q <= cnt_val;
                step_q   <= '0;
                dir_q    <= dir_up;
                err_q    <= 1'b0;
            end
            if (stepping) begin
                shadow_q <= dir_q ? shadow_q + W'(1) : shadow_q - W'(1);
                step_q   <= step_q + W'(1);
            end
            if (state == ST_DONE) begin
                err_q <= (cnt_val != target_q);
            end
        end
    end

    // All outputs decode from registered state only; async reset clears them at once.
    assign cnt_inc    = stepping && dir_q;
    assign cnt_dec    = stepping && !dir_q;
    assign cnt_ld     = (state == ST_LOAD);
    assign cnt_in     = target_q;
    assign busy       = (state != ST_IDLE);
    assign req_ready  = (state == ST_IDLE);
    assign done       = (state == ST_DONE);
    assign err        = err_q;
    assign step_count = step_q;

endmodule

// File: tb/tb_counter_driver.sv
// Scoreboard bench for counter_driver driving a behavioural up/down/load counter.
// Expected results depend on CNT_DRV_SHORTEST_EN for the wrap-around walk only.
module tb_counter_driver;

    localparam int W = 6;

    typedef struct {
        int         acc;
        int         lat;
        int         incs;
        int         decs;
        int         lds;
        logic [W-1:0] ld_data;
        logic [W-1:0] steps;
        logic [W-1:0] cnt;
        logic       err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_mode = 1'b0;
    logic [W-1:0] req_target = '0;
    logic [W-1:0] cnt_val;
    logic         cnt_inc;
    logic         cnt_dec;
    logic         cnt_ld;
    logic [W-1:0] cnt_in;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] step_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t sb_q[$];

    // Load: the counter register, with a fault hook that freezes it.
    logic [W-1:0] cnt_q = '0;
    logic         stuck = 1'b0;

    counter_driver #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_mode   (req_mode),
        .req_target (req_target),
        .cnt_val    (cnt_val),
        .cnt_inc    (cnt_inc),
        .cnt_dec    (cnt_dec),
        .cnt_ld     (cnt_ld),
        .cnt_in     (cnt_in),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!stuck) begin
            if (cnt_ld)       cnt_q <= cnt_in;
            else if (cnt_inc) cnt_q <= cnt_q + 6'd1;
            else if (cnt_dec) cnt_q <= cnt_q - 6'd1;
        end
    end
    assign cnt_val = cnt_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int lat, input int incs, input int decs, input int lds,
                                input logic [W-1:0] ld_data, input logic [W-1:0] steps,
                                input logic [W-1:0] cnt, input logic e);
        exp_t x;
        x.acc = 0; x.lat = lat; x.incs = incs; x.decs = decs; x.lds = lds;
        x.ld_data = ld_data; x.steps = steps; x.cnt = cnt; x.err = e;
        return x;
    endfunction

    // Monitor: counts strobes per request and checks each done against the scoreboard.
    int           n_inc = 0;
    int           n_dec = 0;
    int           n_ld = 0;
    logic [W-1:0] ld_seen = '0;
    logic         both = 1'b0;
    logic         pend = 1'b0;
    logic         pend_err = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                n_inc = 0; n_dec = 0; n_ld = 0; both = 1'b0; pend = 1'b0;
            end else begin
                if (pend) begin
                    check("err_after_done", err, pend_err);
                    pend = 1'b0;
                end
                if (cnt_inc && cnt_dec) both = 1'b1;
                if (cnt_inc) n_inc++;
                if (cnt_dec) n_dec++;
                if (cnt_ld) begin
                    n_ld++;
                    ld_seen = cnt_in;
                end
                if (done) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("done_latency", cyc - e.acc, e.lat);
                        check("inc_strobes", n_inc, e.incs);
                        check("dec_strobes", n_dec, e.decs);
                        check("ld_strobes", n_ld, e.lds);
                        if (e.lds > 0) check("ld_data", ld_seen, e.ld_data);
                        check("step_count", step_count, e.steps);
                        check("counter_value", cnt_val, e.cnt);
                        check("inc_dec_overlap", both, 0);
                        pend     = 1'b1;
                        pend_err = e.err;
                    end
                    n_inc = 0; n_dec = 0; n_ld = 0; both = 1'b0;
                end else if (!busy) begin
                    n_inc = 0; n_dec = 0; n_ld = 0; both = 1'b0;
                end
            end
        end
    end

    // Holds req_valid until the driver is idle; back-to-back calls exercise ignore-while-busy.
    task automatic send(input logic mode, input logic [W-1:0] target, input logic track,
                        input exp_t e);
        exp_t x;
        int   n;
        x          = e;
        req_mode   = mode;
        req_target = target;
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("ready_timeout", 0, 1);
        end else begin
            x.acc = cyc;
            if (track) sb_q.push_back(x);
            @(posedge clk);
        end
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb_q.size() != 0 || busy || pend) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("drain_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_inc", cnt_inc, 0);
        check("rst_dec", cnt_dec, 0);
        check("rst_ld", cnt_ld, 0);
        check("rst_cnt_in", cnt_in, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_step_count", step_count, 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_ready", req_ready, 1);
        check("idle_busy", busy, 0);

        // Preload 5, walk 5->9, equal-target walk, load 37, walk down 37->30
        send(1'b1, 6'd5, 1'b1, mk(2, 0, 0, 1, 6'd5, 6'd0, 6'd5, 1'b0));
        send(1'b0, 6'd9, 1'b1, mk(6, 4, 0, 0, 6'd0, 6'd4, 6'd9, 1'b0));
        send(1'b0, 6'd9, 1'b1, mk(2, 0, 0, 0, 6'd0, 6'd0, 6'd9, 1'b0));
        send(1'b1, 6'd37, 1'b1, mk(2, 0, 0, 1, 6'd37, 6'd0, 6'd37, 1'b0));
        send(1'b0, 6'd30, 1'b1, mk(9, 0, 7, 0, 6'd0, 6'd7, 6'd30, 1'b0));

        // Wrap-around candidate: 2 -> 62
        send(1'b1, 6'd2, 1'b1, mk(2, 0, 0, 1, 6'd2, 6'd0, 6'd2, 1'b0));
`ifdef CNT_DRV_SHORTEST_EN
        send(1'b0, 6'd62, 1'b1, mk(6, 0, 4, 0, 6'd0, 6'd4, 6'd62, 1'b0));
`else
        send(1'b0, 6'd62, 1'b1, mk(62, 60, 0, 0, 6'd0, 6'd60, 6'd62, 1'b0));
`endif
        wait_idle();

        // Reset pulse in the middle of a 5->9 walk
        send(1'b1, 6'd5, 1'b1, mk(2, 0, 0, 1, 6'd5, 6'd0, 6'd5, 1'b0));
        wait_idle();
        send(1'b0, 6'd9, 1'b0, mk(0, 0, 0, 0, 6'd0, 6'd0, 6'd0, 1'b0));
        @(negedge clk);
        check("mid_walk_inc", cnt_inc, 1);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_inc", cnt_inc, 0);
        check("async_rst_dec", cnt_dec, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_steps", step_count, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1);
        check("post_rst_busy", busy, 0);

        // Stuck counter: driver walks its shadow 10->13 but the counter never moves
        send(1'b1, 6'd10, 1'b1, mk(2, 0, 0, 1, 6'd10, 6'd0, 6'd10, 1'b0));
        wait_idle();
        stuck = 1'b1;
        send(1'b0, 6'd13, 1'b1, mk(5, 3, 0, 0, 6'd0, 6'd3, 6'd10, 1'b1));
        wait_idle();
        check("err_sticky", err, 1);
        stuck = 1'b0;
        send(1'b0, 6'd10, 1'b1, mk(2, 0, 0, 0, 6'd0, 6'd0, 6'd10, 1'b0));
        check("err_cleared_on_accept", err, 0);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
